// File: rtl/neuron_mac_seq.sv
`default_nettype none
// neuron_mac_seq: streams activations against fetched weights, accumulates, adds bias, saturates.
// Rev 1.0
module neuron_mac_seq #(
  parameter int NUM_WEIGHT = 3,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         w_ren,
  output logic [9:0]                   w_radd,
  input  logic signed [DATA_WIDTH-1:0] w_rdata,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = PW + 10;

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [9:0]        LAST_IDX = 10'(NUM_WEIGHT - 1);
  localparam logic signed [AW:0] SAT_MAX = (AW+1)'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [AW:0] SAT_MIN = ~SAT_MAX;

  logic [1:0]                   state;
  logic [9:0]                   cnt;
  logic signed [DATA_WIDTH-1:0] x_d;
  logic                         v1;
  logic                         v2;
  logic signed [PW-1:0]         prod_r;
  logic signed [AW-1:0]         acc;

  logic                         accept;
  logic signed [AW-1:0]         acc_sh;
  logic signed [AW:0]           sum_w;
  logic signed [DATA_WIDTH-1:0] sat_w;

  assign in_ready = rst_n & (state == ACCUM);
  assign accept   = in_valid & in_ready;
  assign w_ren    = accept;
  assign w_radd   = cnt;

  // Arithmetic shift floors toward -inf; one guard bit keeps the bias add exact.
  always_comb begin
    acc_sh = acc >>> FRAC_BITS;
    sum_w  = {acc_sh[AW-1], acc_sh} + {{(AW + 1 - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    if (sum_w > SAT_MAX) begin
      sat_w = SAT_MAX[DATA_WIDTH-1:0];
    end else if (sum_w < SAT_MIN) begin
      sat_w = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_w = sum_w[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      cnt       <= '0;
      x_d       <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      prod_r    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        x_d <= in_data;
      end
      v2 <= v1;
      if (v1) begin
        prod_r <= PW'(x_d) * PW'(w_rdata);
      end

      if (state == HOLD && out_valid && out_ready) begin
        acc <= '0;
      end else if (v2) begin
        acc <= acc + {{(AW - PW){prod_r[PW-1]}}, prod_r};
      end

      case (state)
        ACCUM: begin
          if (accept) begin
            if (cnt == LAST_IDX) begin
              cnt   <= '0;
              state <= DRAIN;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
        end
        // Finalise once both pipeline stages have emptied into acc.
        DRAIN: begin
          if (!v1 && !v2) begin
            out_data  <= sat_w;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
`default_nettype wire
